// File: rtl/mem_arb8.sv
// mem_arb8: two-requester (CPU, DMA) arbiter onto one shared single-port memory.
// Latency: grant and memory drive are combinational; read return arrives 1 cycle after grant.
// Backpressure: CPU sees cpu_stall when not granted; DMA holds its request until dma_gnt.
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   cpu_req/we/addr/wdata          CPU request; cpu_stall, cpu_rdata, cpu_rvalid back
//   dma_req/we/addr/wdata          DMA request; dma_gnt, dma_rdata, dma_rvalid back
//   mem_addr/mem_wr/mem_we         shared memory command (mem_wr = write data)
//   mem_rd                         memory read data, valid one cycle after address
module mem_arb8 #(
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DMA} own_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  own_t       own_q, own_d;
  logic [3:0] starve_q, starve_d;
  logic       rd_vld_q, rd_vld_d;
  logic       gnt_cpu, gnt_dma;

  // Grants are forced low during reset so nothing reaches the memory port.
  // The starve count never exceeds STARVE_LIM, so the two grants are exclusive.
  always_comb begin
    gnt_cpu = rst & cpu_req & (~dma_req | (starve_q < STARVE_LIM));
    gnt_dma = rst & dma_req & (~cpu_req | (starve_q == STARVE_LIM));
  end

  // State register: owner of the previous cycle, read tag valid, starve count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q    <= OWN_IDLE;
      rd_vld_q <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      own_q    <= own_d;
      rd_vld_q <= rd_vld_d;
      starve_q <= starve_d;
    end
  end

  // Next state. The read tag's owner is the registered owner, so only the
  // valid bit needs to be kept separately.
  always_comb begin
    own_d    = OWN_IDLE;
    rd_vld_d = 1'b0;
    starve_d = starve_q;
    if (gnt_cpu) begin
      own_d    = OWN_CPU;
      rd_vld_d = ~cpu_we;
    end else if (gnt_dma) begin
      own_d    = OWN_DMA;
      rd_vld_d = ~dma_we;
    end
    if (!dma_req || gnt_dma) begin
      starve_d = 4'd0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Outputs: memory mux, handshakes, read return steering.
  always_comb begin
    mem_addr   = '0;
    mem_wr     = '0;
    mem_we     = 1'b0;
    cpu_rvalid = 1'b0;
    dma_rvalid = 1'b0;
    cpu_rdata  = '0;
    dma_rdata  = '0;
    if (gnt_cpu) begin
      mem_addr = cpu_addr;
      mem_wr   = cpu_wdata;
      mem_we   = cpu_we;
    end else if (gnt_dma) begin
      mem_addr = dma_addr;
      mem_wr   = dma_wdata;
      mem_we   = dma_we;
    end
    cpu_stall = rst & cpu_req & ~gnt_cpu;
    dma_gnt   = gnt_dma;
    if (rst && rd_vld_q) begin
      if (own_q == OWN_CPU) begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mem_rd;
      end else if (own_q == OWN_DMA) begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb8.sv
// tb_mem_arb8: directed-vector bench for mem_arb8 (AW=24, DW=16, STARVE=4).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
// Every check goes through check_val, which keeps the check and error counts.
module tb_mem_arb8;
  localparam int AW = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rd;
  logic          cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wr;
  logic [AW-1:0] mem_addr;

  int n_chk = 0;
  int n_err = 0;

  mem_arb8 #(.AW(AW), .DW(DW), .STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_set(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_c, prev_d, exp_d;

    // Reset asserted with both requesters active: everything must stay quiet.
    rst = 1'b0;
    cpu_set(1'b1, 1'b1, 24'h00ABCD, 16'h5555);
    dma_set(1'b1, 1'b1, 24'h00DCBA, 16'hAAAA);
    mem_rd = 16'hFFFF;
    settle;
    check_val("rst_cpu_stall", cpu_stall, 0);
    check_val("rst_dma_gnt",   dma_gnt,   0);
    check_val("rst_mem_we",    mem_we,    0);
    check_val("rst_mem_addr",  mem_addr,  0);
    check_val("rst_mem_wr",    mem_wr,    0);
    check_val("rst_rvalid",    {cpu_rvalid, dma_rvalid}, 0);
    check_val("rst_rdata",     {cpu_rdata, dma_rdata}, 0);
    next_cycle;

    // CPU read in the first cycle out of reset.
    rst = 1'b1;
    cpu_set(1'b1, 1'b0, 24'h000010, 16'h0000);
    dma_set(1'b0, 1'b0, 24'h0, 16'h0);
    settle;
    check_val("cpurd_stall", cpu_stall, 0);
    check_val("cpurd_addr",  mem_addr, 24'h000010);
    check_val("cpurd_we",    mem_we, 0);
    check_val("cpurd_dgnt",  dma_gnt, 0);
    next_cycle;
    // Idle request lines carry junk that must be ignored.
    cpu_set(1'b0, 1'b1, 24'h123456, 16'h7777);
    mem_rd = 16'hBEEF;
    settle;
    check_val("cpurd_rvalid", cpu_rvalid, 1);
    check_val("cpurd_rdata",  cpu_rdata, 16'hBEEF);
    check_val("cpurd_drv",    dma_rvalid, 0);
    check_val("idle_mem_we",  mem_we, 0);
    check_val("idle_mem_addr", mem_addr, 0);
    next_cycle;
    settle;
    check_val("rv_one_cycle", cpu_rvalid, 0);
    check_val("rdata_zero",   cpu_rdata, 0);
    next_cycle;

    // DMA write with CPU idle.
    cpu_set(1'b0, 1'b0, 24'h0, 16'h0);
    dma_set(1'b1, 1'b1, 24'hFF0FFE, 16'h1234);
    settle;
    check_val("dwr_gnt",  dma_gnt, 1);
    check_val("dwr_we",   mem_we, 1);
    check_val("dwr_addr", mem_addr, 24'hFF0FFE);
    check_val("dwr_data", mem_wr, 16'h1234);
    next_cycle;
    dma_set(1'b0, 1'b0, 24'h0, 16'h0);
    settle;
    check_val("dwr_no_rv", {cpu_rvalid, dma_rvalid}, 0);
    next_cycle;

    // Alternating CPU read then DMA read: back-to-back returns.
    cpu_set(1'b1, 1'b0, 24'h000001, 16'h0);
    settle;
    check_val("alt_cgnt", cpu_stall, 0);
    next_cycle;
    cpu_set(1'b0, 1'b0, 24'h0, 16'h0);
    dma_set(1'b1, 1'b0, 24'h000002, 16'h0);
    mem_rd = 16'h0001;
    settle;
    check_val("alt_dgnt",  dma_gnt, 1);
    check_val("alt_crv",   cpu_rvalid, 1);
    check_val("alt_crd",   cpu_rdata, 16'h0001);
    check_val("alt_drv0",  dma_rvalid, 0);
    next_cycle;
    dma_set(1'b0, 1'b0, 24'h0, 16'h0);
    mem_rd = 16'h0002;
    settle;
    check_val("alt_drv",  dma_rvalid, 1);
    check_val("alt_drd",  dma_rdata, 16'h0002);
    check_val("alt_crv0", cpu_rvalid, 0);
    next_cycle;

    // Both read continuously: DMA wins every 5th cycle.
    prev_c = 1'b0;
    prev_d = 1'b0;
    cpu_set(1'b1, 1'b0, 24'h000100, 16'h0);
    dma_set(1'b1, 1'b0, 24'h000200, 16'h0);
    for (int i = 0; i < 12; i++) begin
      mem_rd = 16'(16'h1000 + i);
      exp_d = (i % 5 == 4);
      settle;
      check_val($sformatf("stv_dgnt_%0d", i),  dma_gnt, exp_d);
      check_val($sformatf("stv_stall_%0d", i), cpu_stall, exp_d);
      check_val($sformatf("stv_addr_%0d", i),  mem_addr, exp_d ? 24'h000200 : 24'h000100);
      check_val($sformatf("stv_crv_%0d", i),   cpu_rvalid, prev_c);
      check_val($sformatf("stv_drv_%0d", i),   dma_rvalid, prev_d);
      check_val($sformatf("stv_crd_%0d", i),   cpu_rdata, prev_c ? 16'(16'h1000 + i) : 16'h0);
      check_val($sformatf("stv_drd_%0d", i),   dma_rdata, prev_d ? 16'(16'h1000 + i) : 16'h0);
      prev_c = ~exp_d;
      prev_d = exp_d;
      next_cycle;
    end
    cpu_set(1'b0, 1'b0, 24'h0, 16'h0);
    dma_set(1'b0, 1'b0, 24'h0, 16'h0);
    next_cycle;

    // DMA waits 3 cycles, drops, reasserts: count restarts, grant on 5th cycle.
    cpu_set(1'b1, 1'b1, 24'h000300, 16'h0);
    for (int i = 0; i < 9; i++) begin
      dma_set(i != 3, 1'b1, 24'h000400, 16'h0);
      settle;
      check_val($sformatf("drop_dgnt_%0d", i), dma_gnt, i == 8);
      next_cycle;
    end

    // Build the starve count, start a CPU read, then reset.
    cpu_set(1'b1, 1'b0, 24'h000500, 16'h0);
    dma_set(1'b1, 1'b0, 24'h000600, 16'h0);
    for (int i = 0; i < 4; i++) begin
      settle;
      check_val($sformatf("pre_rst_dgnt_%0d", i), dma_gnt, 0);
      next_cycle;
    end
    rst = 1'b0;
    mem_rd = 16'hAAAA;
    settle;
    check_val("mid_rst_crv",   cpu_rvalid, 0);
    check_val("mid_rst_crd",   cpu_rdata, 0);
    check_val("mid_rst_stall", cpu_stall, 0);
    check_val("mid_rst_dgnt",  dma_gnt, 0);
    check_val("mid_rst_mem",   {mem_we, mem_addr, mem_wr}, 0);
    next_cycle;
    // Starve count cleared by reset: CPU keeps priority.
    rst = 1'b1;
    settle;
    check_val("post_rst_crv",  cpu_rvalid, 0);
    check_val("post_rst_dgnt", dma_gnt, 0);
    check_val("post_rst_cgnt", cpu_stall, 0);
    next_cycle;
    cpu_set(1'b0, 1'b0, 24'h0, 16'h0);
    settle;
    check_val("post_rst_dma", dma_gnt, 1);
    check_val("post_rst_dad", mem_addr, 24'h000600);
    next_cycle;
    dma_set(1'b0, 1'b0, 24'h0, 16'h0);
    mem_rd = 16'h4242;
    settle;
    check_val("post_rst_drv", dma_rvalid, 1);
    check_val("post_rst_drd", dma_rdata, 16'h4242);
    next_cycle;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
